sysid_checker: RTL and testbench
================================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000: system ID value that a correct device returns at address 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1320974310: build timestamp that a correct device returns at address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, legal range 2..65535: maximum consecutive waitrequest cycles allowed per read.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that requests a check sequence.
REQ-007 SHALL have port avm_address, output, 1 bit: Avalon-MM master address (0 = ID, 1 = timestamp).
REQ-008 SHALL have port avm_read, output, 1 bit: Avalon-MM read request.
REQ-009 SHALL have port avm_waitrequest, input, 1 bit: slave stall signal.
REQ-010 SHALL have port avm_readdata, input, 32 bits: read data, valid when avm_read=1 and avm_waitrequest=0.
REQ-011 SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a sequence ends.
REQ-013 SHALL have port pass, output, 1 bit: the last sequence matched both ID and timestamp and did not time out.
REQ-014 SHALL have port id_ok and port ts_ok, outputs, 1 bit each: per-word compare result of the last sequence.
REQ-015 SHALL have port timeout, output, 1 bit: the last sequence was aborted by the watchdog.
REQ-016 SHALL have port captured_id and port captured_ts, outputs, 32 bits each: raw words read in the last sequence.

Function
REQ-017 SHALL implement an FSM with states IDLE, RD_ID, RD_TS and FIN.
- IDLE: start moves the FSM to RD_ID.
- RD_ID: read-accept moves the FSM to RD_TS.
- RD_TS: read-accept moves the FSM to FIN.
- FIN: moves the FSM to IDLE after exactly one cycle.
REQ-018 SHALL drive avm_read=1 in RD_ID and RD_TS only, and drive avm_address=0 in RD_ID and 1 in RD_TS.
REQ-019 SHALL hold avm_address and avm_read stable while avm_waitrequest=1.
REQ-020 SHALL define read-accept as avm_read=1 and avm_waitrequest=0.
REQ-021 SHALL, on read-accept, register avm_readdata into captured_id or captured_ts, as addressed.
REQ-022 SHALL, with a zero-wait-state slave, complete a sequence in 3 cycles from start sampled to done=1.
REQ-023 SHALL, on entry to RD_ID, clear id_ok, ts_ok, pass and timeout.
REQ-024 SHALL update id_ok and ts_ok on the respective read-accept, using a 32-bit equality compare against EXPECTED_ID / EXPECTED_TS.
REQ-025 SHALL set pass in FIN as id_ok & ts_ok & ~timeout.
REQ-026 SHALL pulse done=1 only in FIN.
REQ-027 SHALL hold busy=1 in RD_ID, RD_TS and FIN.
REQ-028 SHALL ignore start while busy=1; no queueing.
REQ-029 SHALL hold all result outputs until the next sequence starts.
REQ-030 SHALL, when start is asserted in the same cycle as FIN, ignore that start; a new sequence is accepted from IDLE only.

Reset
REQ-031 SHALL, on reset_n=0, immediately and asynchronously force the FSM to IDLE, the watchdog count to 0, and every output to 0.
REQ-032 SHALL, when reset is asserted mid-read, deassert avm_read asynchronously and discard any partial result.

Configuration
REQ-033 SHALL, with SYSID_CHECKER_TIMEOUT_EN defined, include a watchdog:
- counts consecutive cycles of avm_read=1 with avm_waitrequest=1;
- clears on read-accept and on state change;
- on reaching TIMEOUT_CYCLES, sets timeout=1 and moves the FSM to FIN (avm_read drops the next cycle, pass=0).
REQ-034 SHALL, without SYSID_CHECKER_TIMEOUT_EN, omit the watchdog logic entirely, tie timeout to 0, and wait indefinitely on waitrequest.

Structure
REQ-035 SHALL place the state enum and constants ADDR_ID=1'b0 and ADDR_TS=1'b1 in the shared package sysid_checker_pkg.
REQ-036 SHALL implement the watchdog counter as the sub-module sysid_checker_wdog, instantiated only under SYSID_CHECKER_TIMEOUT_EN.

Verification
REQ-037 SHALL cover: zero-wait slave returning 0 and 1320974310 (0x4EBC77E6), start pulse -> done at cycle 3, pass=1, id_ok=1, ts_ok=1.
REQ-038 SHALL cover: slave returning timestamp 0x4EBC77E7 -> pass=0, id_ok=1, ts_ok=0, captured_ts=0x4EBC77E7.
REQ-039 SHALL cover: waitrequest high for 5 cycles on the ID read -> address and read stable for those cycles, done at cycle 8, pass=1.
REQ-040 SHALL cover: TIMEOUT_EN defined, TIMEOUT_CYCLES=4, waitrequest stuck high -> timeout=1 after 4 stalled cycles, pass=0, avm_read=0 thereafter.
REQ-041 SHALL cover: start pulsed again while in RD_TS -> ignored, exactly one done pulse.
REQ-042 SHALL cover: reset_n dropped while in RD_TS -> avm_read=0 and all outputs 0 immediately; a new start after release runs a full sequence.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: shared FSM state type and Avalon address constants
package sysid_checker_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        FIN   = 2'd3
    } state_t;
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;
endpackage

// File: rtl/sysid_checker_wdog.sv
// sysid_checker_wdog: counts consecutive stalled read cycles and flags expiry on the last allowed one
module sysid_checker_wdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_stall,
    input  logic i_clear,
    output logic o_expire
);
    logic [15:0] r_cnt;
    // stall counter restarts whenever the read is accepted, the state moves, or the stall gaps
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else          r_cnt <= (i_clear || !i_stall) ? '0 : r_cnt + 16'd1;
    end
    assign o_expire = i_stall && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: reads system ID and timestamp over Avalon-MM and compares them; watchdog under SYSID_CHECKER_TIMEOUT_EN
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1320974310,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..65535");
    end
    state_t r_state, w_next;
    logic   w_accept, w_expire, w_begin;
    logic   r_pass, r_id_ok, r_ts_ok;
    logic   [31:0] r_captured_id, r_captured_ts;
    assign avm_read    = (r_state == RD_ID) || (r_state == RD_TS);
    assign avm_address = (r_state == RD_TS) ? ADDR_TS : ADDR_ID;
    assign w_accept    = avm_read && !avm_waitrequest;
    assign w_begin     = (r_state == IDLE) && start;
    assign busy        = r_state != IDLE;
    assign done        = r_state == FIN;
    assign pass        = r_pass;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign captured_id = r_captured_id;
    assign captured_ts = r_captured_ts;
`ifdef SYSID_CHECKER_TIMEOUT_EN
    logic r_timeout;
    sysid_checker_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_stall  (avm_read && avm_waitrequest),
        .i_clear  (w_accept || (w_next != r_state)),
        .o_expire (w_expire)
    );
    // timeout flag is cleared when a sequence begins and set when the watchdog aborts a read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_timeout <= 1'b0;
        else          r_timeout <= w_begin ? 1'b0 : (w_expire ? 1'b1 : r_timeout);
    end
    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif
    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    // next state: start only honoured from IDLE, a watchdog abort skips straight to FIN
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = start ? RD_ID : IDLE;
            RD_ID:   w_next = w_expire ? FIN : (w_accept ? RD_TS : RD_ID);
            RD_TS:   w_next = (w_expire || w_accept) ? FIN : RD_TS;
            default: w_next = IDLE;
        endcase
    end
    // capture and compare each word on its accept; pass resolves together with the timestamp word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pass        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_captured_id <= '0;
            r_captured_ts <= '0;
        end else begin
            if (w_begin) begin
                r_pass  <= 1'b0;
                r_id_ok <= 1'b0;
                r_ts_ok <= 1'b0;
            end
            if (w_accept && r_state == RD_ID) begin
                r_captured_id <= avm_readdata;
                r_id_ok       <= avm_readdata == EXPECTED_ID;
            end
            if (w_accept && r_state == RD_TS) begin
                r_captured_ts <= avm_readdata;
                r_ts_ok       <= avm_readdata == EXPECTED_TS;
                r_pass        <= r_id_ok && (avm_readdata == EXPECTED_TS);
            end
        end
    end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed and randomized sequences against a slave/result model; watchdog case under SYSID_CHECKER_TIMEOUT_EN
module tb_sysid_checker;
    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1320974310;
`ifdef SYSID_CHECKER_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 256;
`endif
    localparam int MAX_W = (TO > 6) ? 6 : TO - 2;
    localparam int SL    = (TO > 6) ? 5 : TO - 1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] captured_id, captured_ts;
    int          n_vec = 0;
    int          n_err = 0;

    sysid_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
        .timeout(timeout), .captured_id(captured_id), .captured_ts(captured_ts)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_read"}, 32'(avm_read), 0);
        chk({tag, "_addr"}, 32'(avm_address), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_id_ok"}, 32'(id_ok), 0);
        chk({tag, "_ts_ok"}, 32'(ts_ok), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
        chk({tag, "_cap_id"}, captured_id, 0);
        chk({tag, "_cap_ts"}, captured_ts, 0);
    endtask

    // mode 0: plain, 1: extra start during RD_TS, 2: start during FIN
    task automatic run_seq(input logic [31:0] d_id, input logic [31:0] d_ts,
                           input int w_id, input int w_ts, input int mode);
        int  cyc, ph, st;
        bit  e_id, e_ts;
        e_id = (d_id == EXP_ID);
        e_ts = (d_ts == EXP_TS);
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1; ph = 0; st = 0;
        while (ph < 2 && cyc < 200) begin
            avm_waitrequest = st < ((ph == 0) ? w_id : w_ts);
            avm_readdata = avm_waitrequest ? $urandom : ((ph == 0) ? d_id : d_ts);
            start = (mode == 1) && (ph == 1) && (st == 0);
            chk("seq_read", 32'(avm_read), 1);
            chk("seq_addr", 32'(avm_address), 32'(ph));
            chk("seq_busy", 32'(busy), 1);
            chk("seq_done", 32'(done), 0);
            tick;
            cyc++;
            if (avm_waitrequest) st++;
            else begin ph++; st = 0; end
        end
        avm_waitrequest = 1'b0;
        start = (mode == 2);
        chk("fin_cycle", 32'(cyc), 32'(3 + w_id + w_ts));
        chk("fin_done", 32'(done), 1);
        chk("fin_busy", 32'(busy), 1);
        chk("fin_read", 32'(avm_read), 0);
        chk("fin_pass", 32'(pass), 32'(e_id && e_ts));
        chk("fin_id_ok", 32'(id_ok), 32'(e_id));
        chk("fin_ts_ok", 32'(ts_ok), 32'(e_ts));
        chk("fin_timeout", 32'(timeout), 0);
        chk("fin_cap_id", captured_id, d_id);
        chk("fin_cap_ts", captured_ts, d_ts);
        tick;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("post_done", 32'(done), 0);
            chk("post_busy", 32'(busy), 0);
            chk("post_read", 32'(avm_read), 0);
            chk("hold_pass", 32'(pass), 32'(e_id && e_ts));
            chk("hold_cap_ts", captured_ts, d_ts);
            tick;
        end
    endtask

    initial begin
        logic [31:0] r_id, r_ts;
        #2;
        chk_all_zero("reset");
        tick;
        reset_n = 1'b1;
        tick;
        chk_all_zero("idle");
        run_seq(EXP_ID, EXP_TS, 0, 0, 0);
        run_seq(EXP_ID, 32'h4EBC77E7, 0, 0, 0);
        run_seq(EXP_ID, EXP_TS, SL, 0, 0);
        run_seq(32'hDEAD_BEEF, EXP_TS, 0, 1, 0);
        run_seq(EXP_ID, EXP_TS, 0, 2, 1);
        run_seq(EXP_ID, EXP_TS, 1, 0, 2);
        // reset dropped while the timestamp read is stalled
        start = 1'b1;
        tick;
        start = 1'b0;
        avm_readdata = EXP_ID;
        tick;
        avm_waitrequest = 1'b1;
        chk("rst_pre_addr", 32'(avm_address), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        avm_waitrequest = 1'b0;
        tick;
        #2;
        reset_n = 1'b1;
        tick;
        chk_all_zero("postrst");
        run_seq(EXP_ID, EXP_TS, 0, 0, 0);
`ifdef SYSID_CHECKER_TIMEOUT_EN
        start = 1'b1;
        tick;
        start = 1'b0;
        avm_waitrequest = 1'b1;
        for (int k = 0; k < TO; k++) begin
            chk("to_read", 32'(avm_read), 1);
            chk("to_done", 32'(done), 0);
            tick;
        end
        chk("to_fin_read", 32'(avm_read), 0);
        chk("to_fin_done", 32'(done), 1);
        chk("to_fin_timeout", 32'(timeout), 1);
        chk("to_fin_pass", 32'(pass), 0);
        tick;
        chk("to_post_read", 32'(avm_read), 0);
        chk("to_post_timeout", 32'(timeout), 1);
        chk("to_post_busy", 32'(busy), 0);
        avm_waitrequest = 1'b0;
        run_seq(EXP_ID, EXP_TS, 0, 0, 0);
`endif
        for (int n = 0; n < 25; n++) begin
            r_id = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom;
            r_ts = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom;
            run_seq(r_id, r_ts, $urandom_range(0, MAX_W), $urandom_range(0, MAX_W),
                    $urandom_range(0, 2));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
